// File: rtl/led_pwm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_ctrl_if
// Brief    : Configuration bus bundle between the peripheral-bus slave and the LED PWM block.
// Revision : 1.0
// ============================================================================
interface led_pwm_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int PWM_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PWM_W-1:0] cfg_duty;

    modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty);
    modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty);
endinterface
`default_nettype wire

// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_ctrl
// Brief    : Multi-channel LED PWM generator with static, blink and breathe modes.
// Revision : 1.0
// ============================================================================
module led_pwm_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int PWM_W         = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 64
) (
    input  wire logic              clk,
    input  wire logic              reset,
    led_pwm_ctrl_if.slave          cfg,
    output logic [NUM_CH-1:0]      pwm_o,
    output logic                   period_start
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [PWM_W-1:0]   CNT_MAX   = '1;

    logic [PRESC_W-1:0] presc;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               tick;
    logic               boundary;
    logic               ch_valid;
    logic [PWM_W-1:0]   level [NUM_CH];

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (pwm_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
            period_start <= boundary;
        end
    end

    // One shared blink counter keeps every BLINK channel in phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (boundary) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    generate
        if (NUM_CH == (2 ** CH_W)) begin : g_all_ch_valid
            assign ch_valid = 1'b1;
        end else begin : g_ch_range
            logic [CH_W:0] ch_ext;
            assign ch_ext   = {1'b0, cfg.cfg_ch};
            assign ch_valid = (ch_ext < (CH_W + 1)'(NUM_CH));
        end
    endgenerate

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_t            shadow_mode;
        mode_t            act_mode;
        logic [PWM_W-1:0] shadow_duty;
        logic [PWM_W-1:0] act_duty;
        logic [PWM_W-1:0] lvl;
        logic [PWM_W-1:0] lvl_nxt;
        logic [PWM_W-1:0] lvl_eff;
        logic             dir_up;
        logic             dir_nxt;
        logic             wr_hit;

        assign wr_hit = cfg.cfg_we && ch_valid && (cfg.cfg_ch == CH_W'(i));

        // Breathe step is evaluated against the settings being loaded this boundary.
        always_comb begin
            lvl_nxt = lvl;
            dir_nxt = dir_up;
            if ((shadow_mode != MODE_BREATHE) || (shadow_duty == '0)) begin
                lvl_nxt = '0;
                dir_nxt = 1'b1;
            end else if (lvl > shadow_duty) begin
                lvl_nxt = shadow_duty;
                dir_nxt = 1'b0;
            end else if (dir_up) begin
                if (lvl == shadow_duty) begin
                    lvl_nxt = lvl - PWM_W'(1);
                    dir_nxt = 1'b0;
                end else begin
                    lvl_nxt = lvl + PWM_W'(1);
                    dir_nxt = ((lvl + PWM_W'(1)) != shadow_duty);
                end
            end else if (lvl == '0) begin
                lvl_nxt = '0;
                dir_nxt = 1'b1;
            end else begin
                lvl_nxt = lvl - PWM_W'(1);
                dir_nxt = (lvl == PWM_W'(1));
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_mode <= MODE_OFF;
                shadow_duty <= '0;
                act_mode    <= MODE_OFF;
                act_duty    <= '0;
                lvl         <= '0;
                dir_up      <= 1'b1;
            end else begin
                if (wr_hit) begin
                    shadow_mode <= mode_t'(cfg.cfg_mode);
                    shadow_duty <= cfg.cfg_duty;
                end
                if (boundary) begin
                    act_mode <= shadow_mode;
                    act_duty <= shadow_duty;
                    lvl      <= lvl_nxt;
                    dir_up   <= dir_nxt;
                end
            end
        end

        always_comb begin
            lvl_eff = '0;
            case (act_mode)
                MODE_OFF:     lvl_eff = '0;
                MODE_STATIC:  lvl_eff = act_duty;
                MODE_BLINK:   lvl_eff = blink_phase ? act_duty : '0;
                MODE_BREATHE: lvl_eff = lvl;
                default:      lvl_eff = '0;
            endcase
        end

        assign level[i] = lvl_eff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_o <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_o[i] <= (pwm_cnt < level[i]);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_ctrl
// Brief    : Directed self-checking bench for led_pwm_ctrl.
// Revision : 1.0
// ============================================================================
module tb_led_pwm_ctrl;
    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_STATIC  = 2'd1;
    localparam logic [1:0] M_BLINK   = 2'd2;
    localparam logic [1:0] M_BREATHE = 2'd3;

    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         duty;
        int         exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pwm;
    logic       ps;
    logic [2:0] pwm2;
    logic       ps2;
    int         n_checks = 0;
    int         n_pass = 0;
    vec_t       vecs [8];

    led_pwm_ctrl_if #(.NUM_CH(4), .PWM_W(8)) cfg ();
    led_pwm_ctrl_if #(.NUM_CH(3), .PWM_W(8)) cfg2 ();

    led_pwm_ctrl #(.NUM_CH(4), .PWM_W(8), .PRESCALE(1), .BLINK_PERIODS(2)) dut (
        .clk(clk), .reset(reset), .cfg(cfg), .pwm_o(pwm), .period_start(ps)
    );

    led_pwm_ctrl #(.NUM_CH(3), .PWM_W(8), .PRESCALE(16), .BLINK_PERIODS(64)) dut2 (
        .clk(clk), .reset(reset), .cfg(cfg2), .pwm_o(pwm2), .period_start(ps2)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    task automatic cfg_write(input int ch, input logic [1:0] mode, input int duty);
        cfg.cfg_ch   = 2'(ch);
        cfg.cfg_mode = mode;
        cfg.cfg_duty = 8'(duty);
        cfg.cfg_we   = 1'b1;
        @(negedge clk);
        cfg.cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_start(input string name, input bit sel, input int bound, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < bound) begin
            @(negedge clk);
            cycles++;
            seen = sel ? ps2 : ps;
        end
        check({name, "_seen"}, int'(seen), 1);
    endtask

    // Counts one full period of pwm[ch] starting at a period_start sample;
    // optionally issues a write to ch at in-period sample wr_at.
    task automatic measure_wr(input int ch, input int wr_at, input logic [1:0] wmode,
                              input int wduty, output int highs, output int ps_hits);
        highs   = 0;
        ps_hits = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            highs   += int'(pwm[ch]);
            ps_hits += int'(ps);
            if (i == wr_at) begin
                cfg.cfg_ch   = 2'(ch);
                cfg.cfg_mode = wmode;
                cfg.cfg_duty = 8'(wduty);
                cfg.cfg_we   = 1'b1;
            end else begin
                cfg.cfg_we   = 1'b0;
            end
        end
    endtask

    task automatic measure(input int ch, output int highs);
        int p;
        measure_wr(ch, 0, M_OFF, 0, highs, p);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int h, p, cyc, any_hi, h2, lo2;
        bit seen;
        int blink_exp [6] = '{128, 0, 0, 128, 128, 0};
        int br_exp    [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
        int drop_exp  [4] = '{2, 1, 0, 1};

        vecs[0] = '{ch: 0, mode: M_STATIC, duty: 64,  exp: 64};
        vecs[1] = '{ch: 0, mode: M_STATIC, duty: 0,   exp: 0};
        vecs[2] = '{ch: 0, mode: M_STATIC, duty: 255, exp: 255};
        vecs[3] = '{ch: 1, mode: M_STATIC, duty: 1,   exp: 1};
        vecs[4] = '{ch: 2, mode: M_STATIC, duty: 128, exp: 128};
        vecs[5] = '{ch: 3, mode: M_OFF,    duty: 200, exp: 0};
        vecs[6] = '{ch: 3, mode: M_STATIC, duty: 200, exp: 200};
        vecs[7] = '{ch: 2, mode: M_OFF,    duty: 128, exp: 0};

        cfg.cfg_we = 1'b0;  cfg.cfg_ch = '0;  cfg.cfg_mode = '0;  cfg.cfg_duty = '0;
        cfg2.cfg_we = 1'b0; cfg2.cfg_ch = '0; cfg2.cfg_mode = '0; cfg2.cfg_duty = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_period_start", int'(ps), 0);
        check("reset_pwm_cnt", int'(dut.pwm_cnt), 0);
        reset = 1'b0;
        wait_start("first_period", 1'b0, 600, cyc);
        check("first_period_latency", cyc, 256);

        for (int v = 0; v < 8; v++) begin
            cfg_write(vecs[v].ch, vecs[v].mode, vecs[v].duty);
            wait_start($sformatf("vec%0d_start", v), 1'b0, 600, cyc);
            measure_wr(vecs[v].ch, 0, M_OFF, 0, h, p);
            check($sformatf("vec%0d_highs", v), h, vecs[v].exp);
            check($sformatf("vec%0d_period_pulse", v), p, 1);
        end

        cfg_write(0, M_STATIC, 10);
        cfg_write(0, M_STATIC, 20);
        wait_start("last_write_start", 1'b0, 600, cyc);
        measure(0, h);
        check("last_write_wins", h, 20);

        // Reset mid-period with ch0/ch1/ch3 active.
        repeat (100) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midreset%0d_pwm", k), int'(pwm), 0);
            check($sformatf("midreset%0d_period_start", k), int'(ps), 0);
            check($sformatf("midreset%0d_pwm_cnt", k), int'(dut.pwm_cnt), 0);
        end
        reset  = 1'b0;
        any_hi = 0;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (pwm != '0) any_hi = 1;
            seen = ps;
        end
        check("post_reset_idle", any_hi, 0);
        check("post_reset_latency", cyc, 256);

        cfg_write(1, M_STATIC, 50);
        wait_start("shadow_start", 1'b0, 600, cyc);
        measure(1, h);
        check("shadow_initial", h, 50);
        measure_wr(1, 100, M_STATIC, 200, h, p);
        check("shadow_mid_write_old", h, 50);
        measure_wr(1, 255, M_STATIC, 30, h, p);
        check("shadow_new_duty", h, 200);
        measure(1, h);
        check("shadow_boundary_write_deferred", h, 200);
        measure(1, h);
        check("shadow_boundary_write_applied", h, 30);

        do_reset();
        cfg_write(2, M_BLINK, 128);
        wait_start("blink_start", 1'b0, 600, cyc);
        for (int k = 0; k < 6; k++) begin
            measure(2, h);
            check($sformatf("blink_p%0d", k), h, blink_exp[k]);
        end

        do_reset();
        cfg_write(3, M_BREATHE, 4);
        wait_start("breathe_start", 1'b0, 600, cyc);
        for (int k = 0; k < 9; k++) begin
            measure(3, h);
            check($sformatf("breathe_p%0d", k), h, br_exp[k]);
        end

        do_reset();
        cfg_write(3, M_BREATHE, 4);
        wait_start("breathe_drop_start", 1'b0, 600, cyc);
        for (int k = 0; k < 3; k++) begin
            measure(3, h);
            check($sformatf("breathe_rise_p%0d", k), h, br_exp[k]);
        end
        measure_wr(3, 100, M_BREATHE, 2, h, p);
        check("breathe_peak_before_drop", h, 4);
        for (int k = 0; k < 4; k++) begin
            measure(3, h);
            check($sformatf("breathe_drop_p%0d", k), h, drop_exp[k]);
        end

        // Second instance: prescaled timebase and out-of-range channel writes.
        do_reset();
        cfg2.cfg_ch   = 2'd3;
        cfg2.cfg_mode = M_STATIC;
        cfg2.cfg_duty = 8'd255;
        cfg2.cfg_we   = 1'b1;
        @(negedge clk);
        cfg2.cfg_ch   = 2'd2;
        cfg2.cfg_duty = 8'd128;
        @(negedge clk);
        cfg2.cfg_we   = 1'b0;
        wait_start("prescale_first", 1'b1, 5000, cyc);
        check("prescale_first_latency", cyc + 2, 4096);
        cyc  = 0;
        h2   = 0;
        lo2  = 0;
        seen = 1'b0;
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            h2  += int'(pwm2[2]);
            lo2 += int'(pwm2[0]) + int'(pwm2[1]);
            seen = ps2;
        end
        check("prescale_spacing", cyc, 4096);
        check("prescale_ch2_highs", h2, 2048);
        check("invalid_ch_no_effect", lo2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
